// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier sequencer driving one shared alu
//
// Purpose
//   MUL execution unit. On an accepted start it multiplies a_i by b_i using
//   repeated ADD (acc += mcand) and LSL (mcand <<= 1) operations through a
//   single alu instance. It returns the low WIDTH bits of the product. The
//   core stalls while busy_o is high.
//
// Configuration
//   ALU_MUL_EARLY_EXIT_EN  when defined, the sequence stops as soon as no
//                          multiplier bits remain (b_i == 0 finishes at once).
//                          The product value is the same in both builds.
//
// Ports (alu_mul_seq)
//   clk_i      in   1      clock, all state changes on posedge
//   reset_n_i  in   1      synchronous active-low reset
//   start_i    in   1      request, accepted only while ready_o = 1
//   a_i        in   WIDTH  multiplicand, sampled on the accepting edge
//   b_i        in   WIDTH  multiplier, sampled on the accepting edge
//   ready_o    out  1      idle and able to accept start_i
//   busy_o     out  1      operation in progress (ADD/SHIFT/DONE)
//   done_o     out  1      one-cycle pulse when product_o is updated
//   product_o  out  WIDTH  registered (a*b) mod 2^WIDTH, held until next done
//
// Ports (alu)
//   op_i       in   3      operation select (ALU_OP_*)
//   rs_i       in   WIDTH  first operand
//   rt_i       in   WIDTH  second operand / shift amount
//   rd_o       out  WIDTH  result, carry discarded

`ifndef RegWidth
`define RegWidth 16
`endif

package alu_mul_pkg;
  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_XOR = 3'd4;
  localparam logic [2:0] ALU_OP_LSL = 3'd5;
  localparam logic [2:0] ALU_OP_LSR = 3'd6;
  localparam logic [2:0] ALU_OP_ASR = 3'd7;
endpackage

module alu #(
  parameter int WIDTH = `RegWidth
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic [WIDTH-1:0] rd_o
);
  import alu_mul_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  // Shift amount uses only the low bits of rt, as in the core datapath.
  logic [SH_W-1:0] shamt;
  assign shamt = rt_i[SH_W-1:0];

  always_comb begin
    rd_o = '0;
    case (op_i)
      ALU_OP_ADD: rd_o = rs_i + rt_i;
      ALU_OP_SUB: rd_o = rs_i - rt_i;
      ALU_OP_AND: rd_o = rs_i & rt_i;
      ALU_OP_OR:  rd_o = rs_i | rt_i;
      ALU_OP_XOR: rd_o = rs_i ^ rt_i;
      ALU_OP_LSL: rd_o = rs_i << shamt;
      ALU_OP_LSR: rd_o = rs_i >> shamt;
      ALU_OP_ASR: rd_o = WIDTH'($signed(rs_i) >>> shamt);
      default:    rd_o = '0;
    endcase
  end
endmodule

module alu_mul_seq #(
  parameter int WIDTH = `RegWidth,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  import alu_mul_pkg::ALU_OP_ADD;
  import alu_mul_pkg::ALU_OP_LSL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_rs;
  logic [WIDTH-1:0] alu_rt;
  logic [WIDTH-1:0] alu_rd;

  logic [WIDTH-1:0] mplier_shr;
  logic             last_shift;

  assign mplier_shr = mplier_q >> 1;

  // The counter bounds the run to WIDTH shifts; the early-exit build also
  // stops once the remaining multiplier bits are all zero.
`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_shift = (cnt_q == CNT_W'(1)) || (mplier_shr == '0);
`else
  assign last_shift = (cnt_q == CNT_W'(1));
`endif

  alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (alu_op),
    .rs_i (alu_rs),
    .rt_i (alu_rt),
    .rd_o (alu_rd)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    alu_op    = ALU_OP_ADD;
    alu_rs    = '0;
    alu_rt    = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d    = '0;
          mcand_d  = a_i;
          mplier_d = b_i;
          cnt_d    = CNT_W'(WIDTH);
`ifdef ALU_MUL_EARLY_EXIT_EN
          if (b_i == '0) begin
            state_d   = S_DONE;
            product_d = '0;
          end else if (b_i[0]) begin
            state_d = S_ADD;
          end else begin
            state_d = S_SHIFT;
          end
`else
          state_d = b_i[0] ? S_ADD : S_SHIFT;
`endif
        end
      end

      S_ADD: begin
        alu_op  = ALU_OP_ADD;
        alu_rs  = acc_q;
        alu_rt  = mcand_q;
        acc_d   = alu_rd;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        alu_op   = ALU_OP_LSL;
        alu_rs   = mcand_q;
        alu_rt   = WIDTH'(1);
        mcand_d  = alu_rd;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q - CNT_W'(1);
        if (last_shift) begin
          // Product is loaded on the edge entering DONE so it is valid
          // in the same cycle as the done pulse.
          state_d   = S_DONE;
          product_d = acc_q;
        end else begin
          // mplier[1] is the bit that becomes the LSB after this shift.
          state_d = mplier_q[1] ? S_ADD : S_SHIFT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq
module tb_alu_mul_seq;
  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] product_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          lat_def;
    int          lat_en;
  } vec_t;

  vec_t vecs[8];

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int model_lat(input logic [15:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
    if (b == 16'h0) return 0;
    return msb + 1 + popc(b);
`else
    return 16 + popc(b);
`endif
  endfunction

  // Caller is positioned at a negedge. Waits for ready, launches one op,
  // then checks latency, product, done width and the ready return.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eprod, input int elat,
                        input bit hold, input bit scramble);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_ready_wait"}, 32'(ready_o), 32'd1);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i);
    sb.push_back('{prod: eprod, lat: elat});
    @(negedge clk_i);
    if (!hold) start_i = 1'b0;
    if (scramble) begin
      a_i = 16'($urandom);
      b_i = 16'($urandom);
    end
    chk({name, "_busy"}, {31'd0, busy_o}, 32'd1);
    chk({name, "_not_ready"}, {31'd0, ready_o}, 32'd0);
    lat = 0;
    while (!done_o && lat < 200) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
    e = sb.pop_front();
    chk({name, "_done_seen"}, {31'd0, done_o}, 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(e.lat));
    chk({name, "_product"}, {16'd0, product_o}, {16'd0, e.prod});
    @(negedge clk_i);
    chk({name, "_done_width"}, {31'd0, done_o}, 32'd0);
    chk({name, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    chk({name, "_product_held"}, {16'd0, product_o}, {16'd0, e.prod});
  endtask

  initial begin
    int          done_seen;
    logic [31:0] full;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 18,  5};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 32, 32};
    vecs[2] = '{16'h1234, 16'h0000, 16'h0000, 16,  0};
    vecs[3] = '{16'h0006, 16'h0004, 16'h0018, 17,  4};
    vecs[4] = '{16'h00FF, 16'h0100, 16'hFF00, 17, 10};
    vecs[5] = '{16'h8000, 16'h0002, 16'h0000, 17,  3};
    vecs[6] = '{16'h0001, 16'h8000, 16'h8000, 17, 17};
    vecs[7] = '{16'hABCD, 16'h0001, 16'hABCD, 17,  2};

    reset_n_i = 1'b0;
    start_i   = 1'b0;
    a_i       = '0;
    b_i       = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_product", {16'd0, product_o}, 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat_en, 1'b0, 1'b1);
`else
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat_def, 1'b0, 1'b1);
`endif
    end

    // start held high: each ready window takes exactly one op, inputs
    // scrambled mid-op must not leak into the result.
    run_op("hold0", 16'h0006, 16'h0004, 16'h0018, model_lat(16'h0004), 1'b1, 1'b1);
    run_op("hold1", 16'h0006, 16'h0004, 16'h0018, model_lat(16'h0004), 1'b1, 1'b1);
    start_i = 1'b0;
    @(negedge clk_i);

    // Reset in the middle of an operation aborts it without a done pulse.
    start_i   = 1'b1;
    a_i       = 16'h0007;
    b_i       = 16'h0009;
    done_seen = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (done_o) done_seen++;
      @(negedge clk_i);
    end
    if (done_o) done_seen++;
    reset_n_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_ready", {31'd0, ready_o}, 32'd1);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_product", {16'd0, product_o}, 32'd0);
    run_op("after_abort", 16'h0002, 16'h0003, 16'h0006, model_lat(16'h0003), 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      if (i % 10 == 0) rb = 16'($urandom_range(0, 15));
      full = {16'd0, ra} * {16'd0, rb};
      run_op("rand", ra, rb, full[15:0], model_lat(rb), 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
